// File: rtl/store_forward_buffer.sv
// Post-MEM store buffer: in-order drain to data memory with
// youngest-entry store-to-load forwarding and partial-overlap stall.
module store_forward_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         ST_VALID,
    input  logic [ADDR_WIDTH-1:0]        ST_ADDR,
    input  logic [DATA_WIDTH-1:0]        ST_DATA,
    input  logic [DATA_WIDTH/8-1:0]      ST_MASK,
    output logic                         ST_READY,
    input  logic                         LD_VALID,
    input  logic [ADDR_WIDTH-1:0]        LD_ADDR,
    input  logic [DATA_WIDTH/8-1:0]      LD_MASK,
    output logic                         LD_FWD_HIT,
    output logic [DATA_WIDTH-1:0]        LD_FWD_DATA,
    output logic                         LD_STALL,
    output logic                         MEM_WR_VALID,
    output logic [ADDR_WIDTH-1:0]        MEM_WR_ADDR,
    output logic [DATA_WIDTH-1:0]        MEM_WR_DATA,
    output logic [DATA_WIDTH/8-1:0]      MEM_WR_MASK,
    input  logic                         MEM_WR_READY,
    input  logic                         DRAIN_REQ,
    output logic                         EMPTY,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

    localparam int MW = DATA_WIDTH / 8;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = ADDR_WIDTH - 2;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    logic [WW-1:0]         waddr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [MW-1:0]         mask_q  [DEPTH];

    logic enq;
    logic deq;
    logic [WW-1:0] ld_word;

    logic          found;
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    logic          covers;

    logic unused_addr_lsb;

    assign unused_addr_lsb = ^{ST_ADDR[1:0], LD_ADDR[1:0]};

    assign EMPTY        = (count_q == '0);
    assign COUNT        = count_q;
    assign ST_READY     = (count_q < CW'(DEPTH)) && !DRAIN_REQ;
    assign MEM_WR_VALID = !EMPTY;
    assign MEM_WR_ADDR  = {waddr_q[head_q], 2'b00};
    assign MEM_WR_DATA  = data_q[head_q];
    assign MEM_WR_MASK  = mask_q[head_q];

    assign enq = ST_VALID && ST_READY;
    assign deq = MEM_WR_VALID && MEM_WR_READY;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (deq) begin
            head_d          = head_q + PW'(1);
            valid_d[head_q] = 1'b0;
        end
        if (enq) begin
            tail_d          = tail_q + PW'(1);
            valid_d[tail_q] = 1'b1;
        end
        unique case (1'b1)
            (enq && !deq): count_d = count_q + CW'(1);
            (deq && !enq): count_d = count_q - CW'(1);
            default:       count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage has no reset; valid_q qualifies every use.
    always_ff @(posedge CLK) begin
        if (enq) begin
            waddr_q[tail_q] <= ST_ADDR[ADDR_WIDTH-1:2];
            data_q[tail_q]  <= ST_DATA;
            mask_q[tail_q]  <= ST_MASK;
        end
    end

    assign ld_word = LD_ADDR[ADDR_WIDTH-1:2];

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        found = 1'b0;
        sel   = head_q;
        idx   = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] &&
                (waddr_q[idx] == ld_word) &&
                ((mask_q[idx] & LD_MASK) != '0)) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign covers = ((LD_MASK & ~mask_q[sel]) == '0);

    always_comb begin
        LD_FWD_HIT  = 1'b0;
        LD_STALL    = 1'b0;
        LD_FWD_DATA = '0;
        if (LD_VALID && found) begin
            if (covers) begin
                LD_FWD_HIT  = 1'b1;
                LD_FWD_DATA = data_q[sel];
            end else begin
                LD_STALL = 1'b1;
            end
        end
    end

endmodule

// File: doc/store_forward_buffer.md
Name: store_forward_buffer

Overview:
Post-MEM store buffer for the CPU pipeline. Accepts retiring stores from the MEM stage, queues them in order, and drains them to data memory over a valid/ready write port. Serves younger loads by forwarding buffered store data (store-to-load forwarding), and stalls loads that partially overlap a pending store. It complements the WB-to-MEM load-to-store forwarding path with the store-to-load direction.

Parameters:
DEPTH, 4, number of buffer entries; power of two, >= 2
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, store word width; byte mask width is DATA_WIDTH/8

Ports:
CLK  input  1  clock; all state updates on the rising edge
RESET_N  input  1  asynchronous, active-low reset
ST_VALID  input  1  MEM stage presents a store
ST_ADDR  input  ADDR_WIDTH  store byte address; word index = ST_ADDR[ADDR_WIDTH-1:2]
ST_DATA  input  DATA_WIDTH  store data, already byte-lane aligned
ST_MASK  input  4  byte-enable mask
ST_READY  output  1  buffer can accept a store this cycle
LD_VALID  input  1  MEM stage presents a load for lookup
LD_ADDR  input  ADDR_WIDTH  load byte address
LD_MASK  input  4  bytes the load needs
LD_FWD_HIT  output  1  load is fully served from the buffer
LD_FWD_DATA  output  DATA_WIDTH  forwarded word; valid when LD_FWD_HIT=1
LD_STALL  output  1  load must wait; partial overlap with a pending store
MEM_WR_VALID  output  1  head entry is offered to memory
MEM_WR_ADDR  output  ADDR_WIDTH  head address, with bits [1:0] forced to 0
MEM_WR_DATA  output  DATA_WIDTH  head data
MEM_WR_MASK  output  4  head mask
MEM_WR_READY  input  1  memory accepts the head this cycle
DRAIN_REQ  input  1  fence: hold new stores until the buffer is empty
EMPTY  output  1  no pending entries
COUNT  output  $clog2(DEPTH+1)  number of pending entries

Behaviour:
- Storage is a circular FIFO with head pointer, tail pointer and count; pointers wrap modulo DEPTH.
- Reset (RESET_N=0, asynchronous) clears the pointers, the count and all entry valid bits. Entry data is not cleared.
- Values while in reset: MEM_WR_VALID=0, EMPTY=1, COUNT=0, LD_FWD_HIT=0, LD_STALL=0, ST_READY=1.
- Reset asserted mid-operation discards all pending stores. The memory side sees MEM_WR_VALID drop immediately.
- ST_READY = (COUNT < DEPTH) && !DRAIN_REQ.
  - A full buffer does not accept a store in a cycle where it dequeues; there is no full-bypass path.
- Enqueue happens when ST_VALID && ST_READY. The entry is written at the tail, the tail advances, and the entry is visible from the next cycle.
- Dequeue happens when MEM_WR_VALID && MEM_WR_READY, and the head advances.
  - MEM_WR_VALID = !EMPTY.
  - The MEM_WR_* fields come directly from registered head storage, so they are stable while VALID is held and READY is low.
- On a simultaneous enqueue and dequeue, COUNT is unchanged and both pointers advance.
- Load lookup is combinational with zero latency, using the entries valid at the start of the cycle.
  - A store enqueued in the same cycle is not searched.
  - An entry being dequeued in the same cycle is still searched.
- Match rule: entry word index equals LD_ADDR word index and (entry mask & LD_MASK) != 0. Priority goes to the youngest matching entry.
- Lookup outcomes, in order:
  - LD_VALID=0: HIT=0, STALL=0.
  - No match: HIT=0, STALL=0; the load reads memory.
  - Youngest match covers the load, i.e. (LD_MASK & ~entry mask) == 0: HIT=1, STALL=0, LD_FWD_DATA = entry data.
  - Otherwise: HIT=0, STALL=1. The stall holds until the overlapping entries drain.
  - There is no multi-entry byte merging.
- When HIT=0, LD_FWD_DATA = 0.
- DRAIN_REQ blocks enqueue. EMPTY is the completion indication for the fence.
- COUNT never exceeds DEPTH and never underflows. A dequeue cannot occur while empty because VALID is 0.

Test Plan:
- Reset/idle:
  - Assert RESET_N=0 mid-cycle with 2 entries pending -> MEM_WR_VALID=0, COUNT=0, EMPTY=1 with no clock edge.
  - After release -> ST_READY=1.
- Fill and backpressure: hold MEM_WR_READY=0 and enqueue 5 stores at 0x100,0x104,... -> COUNT=4, ST_READY=0, 5th store not accepted, MEM_WR_ADDR stays 0x100.
- In-order drain with wrap:
  - Set MEM_WR_READY=1 -> writes emerge in order 0x100..0x10C, one per cycle.
  - Enqueue 4 more -> pointers wrap and order is preserved.
  - Simultaneous enqueue and dequeue -> COUNT is unchanged.
- Full forward: store 0x200 data 0x11223344 mask 1111, then store 0x200 data 0xAABBCCDD mask 0001, then load 0x200 mask 0001 -> HIT=1, data 0xAABBCCDD (youngest entry).
- Partial stall:
  - Store 0x300 mask 0011, then load 0x300 mask 1111 -> STALL=1, HIT=0 until the entry drains, then STALL=0, HIT=0.
  - Load 0x304 -> no match, HIT=0, STALL=0.
- Same-cycle and fence:
  - Store 0x400 and load 0x400 in the same cycle -> HIT=0 in that cycle, HIT=1 in the next cycle.
  - DRAIN_REQ=1 with 3 entries pending -> ST_READY=0 until EMPTY=1.
